// File: rtl/tag_free_list.sv
// Dual-lane free-tag pool: hands out up to two rename tags per cycle and takes back up to two retired tags.
// Optional duplicate/range release check compiled in with `define TAG_FL_CHECK_EN.
module tag_free_list #(
    parameter int TAG_W    = 6,
    parameter int NUM_TAGS = 64,
    parameter int CNT_W    = $clog2(NUM_TAGS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alloc_req,
    output logic [1:0]       alloc_avail,
    output logic [TAG_W-1:0] alloc_tag0,
    output logic [TAG_W-1:0] alloc_tag1,
    input  logic [1:0]       rel_valid,
    input  logic [TAG_W-1:0] rel_tag0,
    input  logic [TAG_W-1:0] rel_tag1,
    output logic [CNT_W-1:0] free_count,
    output logic             fl_full,
    output logic             fl_empty,
    output logic             err_overflow,
    output logic             err_dup
);

    localparam int PTR_W = $clog2(NUM_TAGS);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_TAGS);

    typedef logic [NUM_TAGS-1:0][TAG_W-1:0] mem_t;

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < NUM_TAGS; i++) begin
            m[i] = TAG_W'(i);
        end
        return m;
    endfunction

    mem_t             mem;
    mem_t             mem_next;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr1;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr1;
    logic [CNT_W-1:0] count;

    logic       g0;
    logic       g1;
    logic [1:0] na;
    logic [1:0] nr;
    logic       cap0;
    logic       cap1;
    logic       chk0;
    logic       chk1;
    logic       acc0;
    logic       acc1;
    logic       ovf_hit;

    // All visible outputs come from registered state only.
    assign rd_ptr1     = rd_ptr + PTR_W'(1);
    assign wr_ptr1     = wr_ptr + PTR_W'(1);
    assign alloc_avail = {count >= CNT_W'(2), count != '0};
    assign alloc_tag0  = mem[rd_ptr];
    assign alloc_tag1  = mem[rd_ptr1];
    assign free_count  = count;
    assign fl_full     = (count == FULL_CNT);
    assign fl_empty    = (count == '0);

    assign g0 = alloc_req[0] & alloc_avail[0];
    assign g1 = g0 & alloc_req[1] & alloc_avail[1];
    assign na = {1'b0, g0} + {1'b0, g1};

    // Capacity ignores same-cycle allocates; lane 1 sees lane 0's accepted tag.
    assign cap0 = (count < FULL_CNT);
    assign cap1 = acc0 ? (count < (FULL_CNT - CNT_W'(1))) : cap0;
    assign acc0 = rel_valid[0] & cap0 & chk0;
    assign acc1 = rel_valid[1] & cap1 & chk1;
    assign nr   = {1'b0, acc0} + {1'b0, acc1};

    assign ovf_hit = (rel_valid[0] & ~cap0) | (rel_valid[1] & ~cap1);

    // A lone lane-1 release is compacted into the wr_ptr slot.
    always_comb begin
        mem_next = mem;
        if (acc0 | acc1) begin
            mem_next[wr_ptr] = acc0 ? rel_tag0 : rel_tag1;
        end
        if (acc0 & acc1) begin
            mem_next[wr_ptr1] = rel_tag1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem          <= init_mem();
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= FULL_CNT;
            err_overflow <= 1'b0;
        end else begin
            mem    <= mem_next;
            rd_ptr <= rd_ptr + PTR_W'(na);
            wr_ptr <= wr_ptr + PTR_W'(nr);
            count  <= count - CNT_W'(na) + CNT_W'(nr);
            if (ovf_hit) begin
                err_overflow <= 1'b1;
            end
        end
    end

`ifdef TAG_FL_CHECK_EN
    localparam logic [TAG_W:0] TAG_LIM = (TAG_W + 1)'(NUM_TAGS);

    logic [NUM_TAGS-1:0] is_free;
    logic [NUM_TAGS-1:0] free_eff;
    logic [NUM_TAGS-1:0] is_free_next;
    logic [PTR_W-1:0]    idx0;
    logic [PTR_W-1:0]    idx1;
    logic                in_range0;
    logic                in_range1;
    logic                dup_hit;

    assign idx0      = rel_tag0[PTR_W-1:0];
    assign idx1      = rel_tag1[PTR_W-1:0];
    assign in_range0 = ({1'b0, rel_tag0} < TAG_LIM);
    assign in_range1 = ({1'b0, rel_tag1} < TAG_LIM);

    // Tags granted this cycle already count as in-flight for the release check.
    always_comb begin
        free_eff = is_free;
        if (g0) begin
            free_eff[alloc_tag0[PTR_W-1:0]] = 1'b0;
        end
        if (g1) begin
            free_eff[alloc_tag1[PTR_W-1:0]] = 1'b0;
        end
    end

    assign chk0 = in_range0 & ~free_eff[idx0];
    assign chk1 = in_range1 & ~free_eff[idx1]
                & ~(rel_valid[0] & (rel_tag0 == rel_tag1));

    always_comb begin
        is_free_next = free_eff;
        if (acc0) begin
            is_free_next[idx0] = 1'b1;
        end
        if (acc1) begin
            is_free_next[idx1] = 1'b1;
        end
    end

    assign dup_hit = (rel_valid[0] & ~chk0) | (rel_valid[1] & ~chk1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_free <= '1;
            err_dup <= 1'b0;
        end else begin
            is_free <= is_free_next;
            if (dup_hit) begin
                err_dup <= 1'b1;
            end
        end
    end
`else
    assign chk0    = 1'b1;
    assign chk1    = 1'b1;
    assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_tag_free_list.sv
// Testbench for tag_free_list: fixed vector table, directed corner sequences and a randomized run
// against a queue-based reference model of the free pool.
module tb_tag_free_list;

    localparam int TAG_W    = 7;
    localparam int NUM_TAGS = 64;
    localparam int CNT_W    = $clog2(NUM_TAGS) + 1;
`ifdef TAG_FL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       alloc_req = '0;
    logic [1:0]       rel_valid = '0;
    logic [TAG_W-1:0] rel_tag0 = '0;
    logic [TAG_W-1:0] rel_tag1 = '0;
    logic [1:0]       alloc_avail;
    logic [TAG_W-1:0] alloc_tag0;
    logic [TAG_W-1:0] alloc_tag1;
    logic [CNT_W-1:0] free_count;
    logic             fl_full;
    logic             fl_empty;
    logic             err_overflow;
    logic             err_dup;

    always #5 clk = ~clk;

    tag_free_list #(.TAG_W(TAG_W), .NUM_TAGS(NUM_TAGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_avail(alloc_avail),
        .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
        .rel_valid(rel_valid), .rel_tag0(rel_tag0), .rel_tag1(rel_tag1),
        .free_count(free_count), .fl_full(fl_full), .fl_empty(fl_empty),
        .err_overflow(err_overflow), .err_dup(err_dup)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the pool is an ordered list of tags, releases are processed lane by lane.
    int mq[$];
    bit mfree[1 << TAG_W];
    bit m_ovf;
    bit m_dup;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < NUM_TAGS; i++) mq.push_back(i);
        for (int i = 0; i < (1 << TAG_W); i++) mfree[i] = (i < NUM_TAGS);
        m_ovf = 1'b0;
        m_dup = 1'b0;
    endfunction

    function automatic void model_cycle(input logic [1:0] req, input logic [1:0] rv,
                                        input int t0, input int t1);
        int cnt = mq.size();
        int room = NUM_TAGS - cnt;
        int tags[2];
        bit take0 = req[0] && cnt >= 1;
        bit take1 = take0 && req[1] && cnt >= 2;
        tags[0] = t0;
        tags[1] = t1;
        if (take0) mfree[mq.pop_front()] = 1'b0;
        if (take1) mfree[mq.pop_front()] = 1'b0;
        for (int l = 0; l < 2; l++) begin
            bit ok_cap;
            bit ok_chk;
            if (!rv[l]) continue;
            ok_cap = room > 0;
            ok_chk = !CHK || (tags[l] < NUM_TAGS && !mfree[tags[l]]);
            if (!ok_cap) m_ovf = 1'b1;
            if (!ok_chk) m_dup = 1'b1;
            if (ok_cap && ok_chk) begin
                mq.push_back(tags[l]);
                mfree[tags[l]] = 1'b1;
                room--;
            end
        end
    endfunction

    task automatic check_model();
        int cnt = mq.size();
        chk("m_count", free_count, cnt);
        chk("m_avail", alloc_avail, {30'd0, cnt >= 2, cnt >= 1});
        chk("m_full", fl_full, cnt == NUM_TAGS);
        chk("m_empty", fl_empty, cnt == 0);
        if (cnt >= 1) chk("m_tag0", alloc_tag0, mq[0]);
        if (cnt >= 2) chk("m_tag1", alloc_tag1, mq[1]);
        chk("m_ovf", err_overflow, m_ovf);
        chk("m_dup", err_dup, m_dup);
    endtask

    task automatic step(input logic r, input logic [1:0] req, input logic [1:0] rv,
                        input int t0, input int t1);
        @(negedge clk);
        rst_n     = r;
        alloc_req = req;
        rel_valid = rv;
        rel_tag0  = TAG_W'(t0);
        rel_tag1  = TAG_W'(t1);
        if (!r) model_reset();
        else model_cycle(req, rv, t0, t1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] rv;
        int         t0;
        int         t1;
        int         cnt;
        int         tag0;
        int         tag1;
        logic [1:0] avail;
        logic       ovf;
        logic       dup;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'b11, 2'b00, 0, 0, 62, 2, 3, 2'b11, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 2'b00, 0, 0, 61, 3, 4, 2'b11, 1'b0, 1'b0};
        vecs[2] = '{2'b10, 2'b00, 0, 0, 61, 3, 4, 2'b11, 1'b0, 1'b0};
        vecs[3] = '{2'b00, 2'b11, 0, 1, 63, 3, 4, 2'b11, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 2'b01, 2, 0, 62, 5, 6, 2'b11, 1'b0, 1'b0};
        vecs[5] = '{2'b00, 2'b10, 0, 3, 63, 5, 6, 2'b11, 1'b0, 1'b0};
        vecs[6] = '{2'b00, 2'b11, 4, 5, 64, 5, 6, 2'b11, 1'b1, CHK};
        vecs[7] = '{2'b00, 2'b01, 9, 0, 64, 5, 6, 2'b11, 1'b1, CHK};

        // Reset state.
        step(1'b0, 2'b00, 2'b00, 0, 0);
        chk("rst_count", free_count, NUM_TAGS);
        chk("rst_full", fl_full, 1);
        chk("rst_empty", fl_empty, 0);
        chk("rst_avail", alloc_avail, 2'b11);
        chk("rst_tag0", alloc_tag0, 0);
        chk("rst_tag1", alloc_tag1, 1);
        chk("rst_ovf", err_overflow, 0);
        chk("rst_dup", err_dup, 0);

        // Vector table.
        for (int v = 0; v < 8; v++) begin
            step(1'b1, vecs[v].req, vecs[v].rv, vecs[v].t0, vecs[v].t1);
            chk($sformatf("vec%0d_count", v), free_count, vecs[v].cnt);
            chk($sformatf("vec%0d_tag0", v), alloc_tag0, vecs[v].tag0);
            chk($sformatf("vec%0d_tag1", v), alloc_tag1, vecs[v].tag1);
            chk($sformatf("vec%0d_avail", v), alloc_avail, vecs[v].avail);
            chk($sformatf("vec%0d_ovf", v), err_overflow, vecs[v].ovf);
            chk($sformatf("vec%0d_dup", v), err_dup, vecs[v].dup);
        end

        // Drain the whole pool two at a time.
        step(1'b0, 2'b00, 2'b00, 0, 0);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("drain%0d_tag0", k), alloc_tag0, 2 * k);
            chk($sformatf("drain%0d_tag1", k), alloc_tag1, 2 * k + 1);
            step(1'b1, 2'b11, 2'b00, 0, 0);
        end
        chk("drain_count", free_count, 0);
        chk("drain_empty", fl_empty, 1);
        chk("drain_avail", alloc_avail, 2'b00);

        // Dual request with a single free tag grants lane 0 only.
        step(1'b1, 2'b00, 2'b01, 7, 0);
        chk("one_count", free_count, 1);
        chk("one_avail", alloc_avail, 2'b01);
        chk("one_tag0", alloc_tag0, 7);
        step(1'b1, 2'b11, 2'b00, 0, 0);
        chk("one_after_count", free_count, 0);
        chk("one_after_avail", alloc_avail, 2'b00);
        chk("one_after_empty", fl_empty, 1);

        // Dual release into an empty pool.
        step(1'b1, 2'b00, 2'b11, 5, 9);
        chk("rel2_tag0", alloc_tag0, 5);
        chk("rel2_tag1", alloc_tag1, 9);
        chk("rel2_count", free_count, 2);

        // Fill to 10, then allocate two while releasing two.
        for (int j = 0; j < 4; j++) step(1'b1, 2'b00, 2'b11, 10 + 2 * j, 11 + 2 * j);
        chk("fill10_count", free_count, 10);
        step(1'b1, 2'b11, 2'b11, 18, 19);
        chk("mix_count", free_count, 10);
        chk("mix_tag0", alloc_tag0, 10);
        chk("mix_tag1", alloc_tag1, 11);
        check_model();

        // Release into a full pool: dropped, sticky until reset.
        step(1'b0, 2'b00, 2'b00, 0, 0);
        step(1'b1, 2'b00, 2'b01, 3, 0);
        chk("ovf_count", free_count, NUM_TAGS);
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_dup", err_dup, CHK);
        for (int j = 0; j < 3; j++) step(1'b1, 2'b01, 2'b00, 0, 0);
        chk("ovf_sticky", err_overflow, 1);
        step(1'b0, 2'b00, 2'b00, 0, 0);
        chk("ovf_cleared", err_overflow, 0);

`ifdef TAG_FL_CHECK_EN
        step(1'b1, 2'b01, 2'b00, 0, 0);
        chk("dup_pre_count", free_count, NUM_TAGS - 1);
        step(1'b1, 2'b00, 2'b11, 7, 70);
        chk("dup_count", free_count, NUM_TAGS - 1);
        chk("dup_flag", err_dup, 1);
        chk("dup_ovf", err_overflow, 0);
        step(1'b1, 2'b00, 2'b01, 0, 0);
        chk("dup_ok_count", free_count, NUM_TAGS);
        chk("dup_ok_full", fl_full, 1);
        step(1'b0, 2'b00, 2'b00, 0, 0);
`endif

        // Randomized run against the reference model, alternating drain-heavy and refill-heavy windows.
        check_model();
        for (int c = 0; c < 3000; c++) begin
            bit         drain_phase = ((c / 120) % 2) == 0;
            logic       r = ($urandom_range(0, 399) != 0);
            logic [1:0] req;
            logic [1:0] rv;
            if (drain_phase) begin
                req = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
                rv  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            end else begin
                req = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                rv  = 2'($urandom_range(0, 3));
            end
            step(r, req, rv, $urandom_range(0, 79), $urandom_range(0, 79));
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tag_free_list.md
# tag_free_list

Dual-lane free-tag list for the dispatcher: holds the pool of unused rename tags, hands out up to two tags per cycle to the Register Status Table, and accepts up to two retired tags per cycle from the CDB. It is the parametrised successor of the single-lane tag FIFO, with these additions:
- configurable tag width and pool depth;
- two-wide allocate and release;
- an occupancy count;
- sticky error flags for illegal releases.

## Interface
- `TAG_W`, 6, tag width in bits.
- `NUM_TAGS`, 64, pool depth. Must be a power of two, at least 4 and at most 2^TAG_W.
- `CNT_W`, $clog2(NUM_TAGS)+1, width of the occupancy count. Derived; not to be overridden.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `alloc_req`  in  2  allocate request. Legal encodings are 00, 01 and 11; 10 is treated as 00.
- `alloc_avail`  out  2  bit0 = count>=1, bit1 = count>=2.
- `alloc_tag0`  out  TAG_W  next free tag (head).
- `alloc_tag1`  out  TAG_W  free tag after head.
- `rel_valid`  in  2  release valid per lane; any encoding is legal.
- `rel_tag0`, `rel_tag1`  in  TAG_W  tags being returned.
- `free_count`  out  CNT_W  number of free tags.
- `fl_full`  out  1  free_count == NUM_TAGS.
- `fl_empty`  out  1  free_count == 0.
- `err_overflow`  out  1  sticky: a release was dropped because the pool was full.
- `err_dup`  out  1  sticky: a release was dropped because the tag was duplicate or out of range. Only driven when the check is compiled in; otherwise tied 0.

## Operation
- Storage: circular array `NUM_TAGS` × `TAG_W`, read pointer `rd_ptr`, write pointer `wr_ptr`, register `count`.
  - Pointers are $clog2(NUM_TAGS) bits wide and wrap naturally at NUM_TAGS-1 → 0.
  - `count` is the only source of full/empty; there is no pointer-equality ambiguity.
- Reset (`rst_n`=0 at an edge):
  - mem[i]=i; rd_ptr=0; wr_ptr=0; count=NUM_TAGS.
  - Resulting outputs: fl_full=1, fl_empty=0, alloc_avail=11, alloc_tag0=0, alloc_tag1=1, both error flags cleared.
  - Reset asserted mid-operation discards all in-flight state identically.
- Allocate:
  - g0 = alloc_req[0] & alloc_avail[0]; g1 = g0 & alloc_req[1] & alloc_avail[1]; na = g0+g1.
  - rd_ptr += na.
  - A 11 request with count==1 grants lane 0 only. The consumer must sample alloc_avail.
- Release:
  - Lanes are processed in order: lane 0 first, then lane 1.
  - A lane is accepted if rel_valid is set, count + (lane 0 accepted ? 1 : 0) < NUM_TAGS, and (with the check) the tag passes the duplicate/range check.
  - Accepted tags are written at wr_ptr and wr_ptr+1 in lane order, compacting so that a lone lane-1 release writes at wr_ptr. wr_ptr += nr.
  - Same-cycle allocates are not credited toward release capacity. A release into a full pool is dropped and sets err_overflow.
- Count update: count_next = count - na + nr. Allocate and release in the same cycle are both applied.
- Slot safety: write slots never alias unread slots, because nr is bounded by NUM_TAGS-count.
- Error flags are cleared only by reset.

## Timing
- alloc_tag0/1, alloc_avail, free_count, fl_full and fl_empty are combinational from registered state only, with no path from any input.
- Allocation takes effect at the edge where the grant is computed. The next tags appear the following cycle.
- Zero-latency bypass is not provided. A tag released in cycle N is allocatable no earlier than cycle N+1, and only once it reaches the head.
- Error flags assert in the cycle after the offending release.

## Configuration
- `TAG_FL_CHECK_EN` defined:
  - Adds a NUM_TAGS-bit `is_free` vector. Reset sets all bits to 1.
  - Allocate clears the bit; accepted release sets it.
  - A release is rejected and sets err_dup if:
    - its tag is ≥ NUM_TAGS;
    - `is_free[tag]` is already set;
    - both lanes carry the same tag (lane 1 is rejected).
  - A tag allocated this cycle counts as not free for a same-cycle release check.
- Not defined:
  - No `is_free` vector; releases are checked only for capacity.
  - err_dup is tied 0.

## Test plan
- Reset, then alloc_req=11 for 32 cycles. Required: tag pairs (0,1)…(62,63); free_count reaches 0, fl_empty=1, alloc_avail=00.
- count=1 with alloc_req=11. Required: only lane 0 is granted; count becomes 0; the next cycle's alloc_tag0 is invalid with alloc_avail=00.
- Empty pool; release tags 5 and 9 on both lanes. Required: the next cycle shows alloc_tag0=5, alloc_tag1=9, count=2.
- count=10; alloc 11 while releasing 2 tags in the same cycle. Required: count=10 next cycle, pointers advanced by 2 each.
- Full pool (after reset); release tag 3. Required: the release is dropped, count stays 64, err_overflow=1 and stays set until `rst_n` low.
- With `TAG_FL_CHECK_EN`: allocate tag 0, then release tag 7 (already free) and tag 70 (out of range). Required: both dropped, err_dup=1. Releasing tag 0 is accepted, count=64.
